decoder_scan: RTL
=================

# decoder_scan

Parametrised N-to-2^N one-hot decoder with registered outputs and two modes. In direct mode it decodes a loaded select value. In scan mode an internal counter steps the active output through 0..limit, dwelling a fixed number of cycles per position. It is the general-width, sequential successor to the team's fixed 3-to-8 combinational decoder, and it drives row/digit-select and chip-select fan-out wherever a time-multiplexed one-hot strobe is needed.

## Interface
- N, default 3: select width; output width is 2^N.
- DWELL, default 4: cycles spent on each position in scan mode; legal range 1..2^16.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global enable; low forces all outputs inactive.
- mode  in  1  0 = DIRECT, 1 = SCAN.
- load  in  1  one-cycle strobe; captures sel into the position register.
- sel  in  N  position to load.
- limit  in  N  last position of the scan range (inclusive); sampled every cycle.
- y  out  2^N  registered one-hot output; all-zero when inactive.
- idx  out  N  registered current position; always coherent with y.
- wrap  out  1  one-cycle pulse when a scan step returns from the end of range to 0.

## Operation
- States: IDLE (en=0), DIRECT (en=1, mode=0), SCAN (en=1, mode=1). Each cycle, the state is derived from the sampled en and mode.
- Reset: y=0, idx=0, wrap=0, dwell count dcnt=0, state IDLE. rst overrides every other input, including rst asserted mid-scan.
- IDLE:
  - Next-cycle y=0 and wrap=0.
  - idx and dcnt are held.
  - load is ignored.
- DIRECT:
  - load=1 gives idx<=sel and y<=1<<sel on the next edge.
  - Without load, idx is held.
  - dcnt is held. wrap=0.
- SCAN, dwell counting:
  - dcnt counts 0..DWELL-1.
  - When dcnt==DWELL-1 (a step cycle), dcnt<=0 and the position advances.
  - Otherwise dcnt<=dcnt+1.
- SCAN, advance rule:
  - If idx>=limit, idx<=0 and wrap<=1.
  - Else idx<=idx+1 and wrap<=0.
  - wrap is 0 in every non-step cycle.
- SCAN, load:
  - load has priority over the step: idx<=sel, dcnt<=0, wrap<=0.
  - A sel above limit is accepted. The next step then wraps to 0 and pulses wrap.
- Limit changes mid-scan take effect at the next step. If idx is already above limit at that step, it wraps to 0.
- limit=0: idx stays at 0, and wrap pulses every DWELL cycles.
- DWELL=1: a step occurs every SCAN cycle. dcnt stays 0 (single-value counter).
- Mode switches:
  - DIRECT to SCAN: scanning resumes from the current idx with the held dcnt.
  - SCAN to DIRECT: idx freezes at its current value.
- Enable:
  - Falling en freezes idx and dcnt.
  - On rising en, y shows 1<<idx on the next edge and scanning resumes where it stopped.
- Invariant: y == (state_q != IDLE) ? (1<<idx) : 0 on every cycle. y is never multi-hot.

## Timing
- All outputs are registered. Latency from any input to y, idx or wrap is 1 cycle.
- No combinational path from any input to any output.
- wrap is asserted in the same cycle that idx first shows 0 after a wrap.
- Scan period = (limit+1)·DWELL cycles, with no load and no enable gaps.
- Full-range wrap at limit=2^N-1 uses the same rule (idx>=limit). There is no reliance on natural N-bit overflow.

## Structure
- Shared package decoder_pkg holds:
  - the state typedef (IDLE/DIRECT/SCAN);
  - the constants MODE_DIRECT=0 and MODE_SCAN=1;
  - a one-hot decode function parametrised by N.
- Sub-module dwell_timer, parameter DWELL:
  - Inputs: clk, rst, run, clear.
  - Output: step, a combinational flag that is high when the count equals DWELL-1 and run=1.
  - It is the natural single sub-module.
- The top level holds the state register, the position register, and the y/wrap output registers.

## Test plan
- Reset with N=3: after reset, y=0x00, idx=0, wrap=0. With rst held, en=1, mode=1 and load=1 for 10 cycles, all outputs stay at 0.
- DIRECT, N=3: en=1, mode=0, load with sel=5 gives y=0x20 and idx=5 one cycle later. With load=0 these hold for 20 cycles.
- SCAN, N=3, DWELL=4, limit=7: y steps 0x01, 0x02 … 0x80, each held for 4 cycles. After 32 cycles, y=0x01, with wrap high for exactly that one cycle.
- SCAN with limit=2, then load sel=6: y=0x40 for 4 cycles, then y=0x01 with a wrap pulse. The sequence then runs 0x01, 0x02, 0x04, 0x01, …
- Enable gap mid-dwell:
  - Setup: SCAN, DWELL=4; drop en at idx=3 with dcnt=1.
  - While en is low: y=0 and idx=3 for 10 cycles.
  - After en rises: y=0x08 for 2 more cycles before stepping to 0x10.
- DWELL=1 with limit=0: y=0x01 constantly, and wrap is high on every SCAN cycle.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types, mode constants and one-hot decode helper for decoder_scan.
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Widest select the helper can decode; callers size-cast the result to 2^N.
    localparam int unsigned MAX_N = 8;
    localparam int unsigned MAX_W = 1 << MAX_N;

    // One-hot decode of pos for an n-bit select; positions outside 2^n decode to zero.
    function automatic logic [MAX_W-1:0] onehot(input logic [MAX_N-1:0] pos,
                                                input int unsigned     n);
        logic [MAX_W-1:0] v;
        v = '0;
        if (32'(pos) < (32'd1 << n))
            v[pos] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/decoder_scan_dwell_timer.sv
// Dwell counter for scan mode: counts 0..DWELL-1 while running, flags the last cycle.
module dwell_timer #(
    parameter int unsigned DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic step
);

    // DWELL=1 still needs a one-bit counter; it never leaves zero.
    localparam int unsigned CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] dcnt;

    assign step = run && (dcnt == LAST);

    // Count while running, restart on clear or after the last dwell cycle; hold otherwise.
    always_ff @(posedge clk) begin
        if (rst)
            dcnt <= '0;
        else if (clear)
            dcnt <= '0;
        else if (run)
            dcnt <= step ? '0 : dcnt + 1'b1;
    end

endmodule

// File: rtl/decoder_scan.sv
// N-to-2^N one-hot decoder with registered outputs; direct (loaded) or scanning position.
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int unsigned N     = 3,
    parameter int unsigned DWELL = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic              load,
    input  logic [N-1:0]      sel,
    input  logic [N-1:0]      limit,
    output logic [(1<<N)-1:0] y,
    output logic [N-1:0]      idx,
    output logic              wrap
);

    localparam int unsigned W = 1 << N;

    state_t       state_q;
    state_t       st_d;
    logic [N-1:0] idx_d;
    logic         wrap_d;
    logic [W-1:0] y_d;
    logic         scan_on;
    logic         step;

    assign scan_on = en && (mode == MODE_SCAN);

    dwell_timer #(.DWELL(DWELL)) u_dwell (
        .clk   (clk),
        .rst   (rst),
        .run   (scan_on),
        .clear (scan_on && load),
        .step  (step)
    );

    // Next state from sampled en/mode, then next position/wrap; y is decoded from the next position
    // so that the registered y always matches the registered idx.
    always_comb begin
        st_d   = IDLE;
        idx_d  = idx;
        wrap_d = 1'b0;
        if (en)
            st_d = (mode == MODE_SCAN) ? SCAN : DIRECT;
        case (st_d)
            DIRECT: begin
                if (load)
                    idx_d = sel;
            end
            SCAN: begin
                if (load) begin
                    idx_d = sel;
                end else if (step) begin
                    if (idx >= limit) begin
                        idx_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        idx_d = idx + 1'b1;
                    end
                end
            end
            default: ;
        endcase
        y_d = (st_d != IDLE) ? W'(onehot(MAX_N'(idx_d), N)) : '0;
    end

    // State, position and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx     <= '0;
            y       <= '0;
            wrap    <= 1'b0;
        end else begin
            state_q <= st_d;
            idx     <= idx_d;
            y       <= y_d;
            wrap    <= wrap_d;
        end
    end

    // y is the decode of idx whenever the block is active, and zero when idle.
    assert property (@(posedge clk)
        y == ((state_q != IDLE) ? W'(onehot(MAX_N'(idx), N)) : {W{1'b0}}));

endmodule
